wc_to_sc: RTL and testbench



---
 rtl/wc_to_sc.sv | 136 +++++++++++++
 tb/tb_wc_to_sc.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/wc_to_sc.sv
// World-to-screen coordinate converter: pixel = round(wc * res_y), clamped to the screen.
// Optional macro WC_TO_SC_Y_FLIP_EN mirrors y so that screen row 0 is at the top.
module wc_to_sc #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int SC_WIDTH   = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    x_wc,
  input  logic [WIDTH-1:0]    y_wc,
  input  logic [SC_WIDTH-1:0] res_x,
  input  logic [SC_WIDTH-1:0] res_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SC_WIDTH-1:0] x_sc,
  output logic [SC_WIDTH-1:0] y_sc,
  output logic                clipped
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // MUL   | one shift-add step per cycle over the bits of res_y
  // CLAMP | round, scale down, clamp and register the result
  // DONE  | holding the result until the consumer takes it

  localparam int ACC_W = WIDTH + SC_WIDTH;
  localparam int VW    = ACC_W - FRAC_WIDTH;
  localparam int CNT_W = $clog2(SC_WIDTH);

  localparam logic [ACC_W-1:0]    ROUND    = ACC_W'(1) << (FRAC_WIDTH - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SC_WIDTH - 1);
  localparam logic [SC_WIDTH-1:0] ONE      = SC_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CLAMP, S_DONE} state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_x, r_y;
  logic [SC_WIDTH-1:0] r_res_x, r_res_y;
  logic [ACC_W-1:0]    r_acc_x, r_acc_y;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_in_ready, r_out_valid, r_clipped;
  logic [SC_WIDTH-1:0] r_x_sc, r_y_sc;

  logic [ACC_W-1:0]    w_x_term, w_y_term, w_x_rnd, w_y_rnd;
  logic [VW-1:0]       w_x_v, w_y_v;
  logic [SC_WIDTH:0]   w_x_cl, w_y_cl;
  logic [SC_WIDTH-1:0] w_y_out;

  // Returns {clip_flag, value}; a zero resolution yields 0 instead of underflowing.
  function automatic logic [SC_WIDTH:0] clamp_v(input logic [VW-1:0] v, input logic [SC_WIDTH-1:0] res);
    if (v[VW-1] || res == '0)
      return {1'b1, {SC_WIDTH{1'b0}}};
    else if (v >= {{(VW-SC_WIDTH){1'b0}}, res})
      return {1'b1, res - ONE};
    else
      return {1'b0, v[SC_WIDTH-1:0]};
  endfunction

  assign w_x_term = {{SC_WIDTH{r_x[WIDTH-1]}}, r_x} << r_cnt;
  assign w_y_term = {{SC_WIDTH{r_y[WIDTH-1]}}, r_y} << r_cnt;
  assign w_x_rnd  = r_acc_x + ROUND;
  assign w_y_rnd  = r_acc_y + ROUND;
  assign w_x_v    = w_x_rnd[ACC_W-1:FRAC_WIDTH];
  assign w_y_v    = w_y_rnd[ACC_W-1:FRAC_WIDTH];
  assign w_x_cl   = clamp_v(w_x_v, r_res_x);
  assign w_y_cl   = clamp_v(w_y_v, r_res_y);

`ifdef WC_TO_SC_Y_FLIP_EN
  assign w_y_out = (r_res_y == '0) ? '0 : r_res_y - ONE - w_y_cl[SC_WIDTH-1:0];
`else
  assign w_y_out = w_y_cl[SC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x_sc      <= '0;
      r_y_sc      <= '0;
      r_clipped   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid && r_in_ready) begin
          r_x        <= x_wc;
          r_y        <= y_wc;
          r_res_x    <= res_x;
          r_res_y    <= res_y;
          r_acc_x    <= '0;
          r_acc_y    <= '0;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= S_MUL;
        end
        S_MUL: begin
          if (r_res_y[r_cnt]) begin
            r_acc_x <= r_acc_x + w_x_term;
            r_acc_y <= r_acc_y + w_y_term;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= S_CLAMP;
        end
        S_CLAMP: begin
          r_x_sc      <= w_x_cl[SC_WIDTH-1:0];
          r_y_sc      <= w_y_out;
          r_clipped   <= w_x_cl[SC_WIDTH] | w_y_cl[SC_WIDTH];
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign x_sc      = r_x_sc;
  assign y_sc      = r_y_sc;
  assign clipped   = r_clipped;

endmodule

// File: tb/tb_wc_to_sc.sv
// Directed bench for wc_to_sc: scaling, rounding, clamping, handshake and reset behaviour.
module tb_wc_to_sc;
`ifdef WC_TO_SC_Y_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] x_wc = '0, y_wc = '0;
  logic [10:0] res_x = '0, res_y = '0;
  logic        in_ready, out_valid, clipped;
  logic [10:0] x_sc, y_sc;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  wc_to_sc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_wc(x_wc), .y_wc(y_wc), .res_x(res_x), .res_y(res_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_sc(x_sc), .y_sc(y_sc), .clipped(clipped)
  );

  // Drives one request, returns 1ns after the accept edge with inputs scrambled.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [10:0] rx, input logic [10:0] ry);
    int k = 0;
    @(negedge clk);
    x_wc = x; y_wc = y; res_x = rx; res_y = ry; in_valid = 1'b1;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_wc = 32'h1234_5678; y_wc = 32'h8765_4321; res_x = 11'd3; res_y = 11'd5;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!out_valid && cyc < 40);
    if (!out_valid) cyc = -1;
  endtask

  task automatic handshake(input string nm);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_ovalid_drop: got %0b want 0", nm, out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_iready_back: got %0b want 1", nm, in_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (x_sc !== 11'd0 || y_sc !== 11'd0) begin n_err++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x_sc, y_sc); end
    n_cmp++; if (clipped !== 1'b0) begin n_err++; $display("FAIL reset_clipped: got %0b want 0", clipped); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_case(input string nm, input logic [31:0] x, input logic [31:0] y, input logic [10:0] rx,
                          input logic [10:0] ry, input logic [10:0] ex, input logic [10:0] ey, input logic ec);
    int c;
    send(x, y, rx, ry);
    wait_out(c);
    n_cmp++; if (c != 12) begin n_err++; $display("FAIL %s_latency: got %0d want 12", nm, c); end
    n_cmp++; if (x_sc !== ex) begin n_err++; $display("FAIL %s_x: got %0d want %0d", nm, x_sc, ex); end
    n_cmp++; if (y_sc !== ey) begin n_err++; $display("FAIL %s_y: got %0d want %0d", nm, y_sc, ey); end
    n_cmp++; if (clipped !== ec) begin n_err++; $display("FAIL %s_clipped: got %0b want %0b", nm, clipped, ec); end
    handshake(nm);
  endtask

  task automatic test_unit_scaling();
    run_case("unit", 32'h4000_0000, 32'h2000_0000, 11'd1280, 11'd720, 11'd720, FLIP ? 11'd359 : 11'd360, 1'b0);
  endtask

  task automatic test_rounding();
    run_case("round", 32'h0010_0000, 32'h0000_FFFF, 11'd1280, 11'd512, 11'd1, FLIP ? 11'd511 : 11'd0, 1'b0);
    run_case("round_neg", 32'h4000_0000, 32'hFFFF_FFFF, 11'd721, 11'd720, 11'd720, FLIP ? 11'd719 : 11'd0, 1'b0);
  endtask

  task automatic test_clamping();
    run_case("clamp", 32'h7999_9999, 32'hF000_0000, 11'd1280, 11'd720, 11'd1279, FLIP ? 11'd719 : 11'd0, 1'b1);
    run_case("edge_x", 32'h4000_0000, 32'h0000_0000, 11'd720, 11'd720, 11'd719, FLIP ? 11'd719 : 11'd0, 1'b1);
    run_case("degen", 32'h2000_0000, 32'h2000_0000, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1);
  endtask

  task automatic test_y_extremes();
    run_case("y_zero", 32'h0, 32'h0, 11'd1280, 11'd720, 11'd0, FLIP ? 11'd719 : 11'd0, 1'b0);
    run_case("y_one", 32'h0, 32'h4000_0000, 11'd1280, 11'd720, 11'd0, FLIP ? 11'd0 : 11'd719, 1'b1);
  endtask

  task automatic test_backpressure();
    int c;
    logic [10:0] ey;
    ey = FLIP ? 11'd359 : 11'd360;
    send(32'h4000_0000, 32'h2000_0000, 11'd1280, 11'd720);
    wait_out(c);
    n_cmp++; if (c != 12) begin n_err++; $display("FAIL bp_latency: got %0d want 12", c); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; x_wc = 32'h1000_0000 + i; y_wc = 32'h0; res_x = 11'd100; res_y = 11'd100;
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || x_sc !== 11'd720 || y_sc !== ey || clipped !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%0b x=%0d y=%0d c=%0b r=%0b want 1,720,%0d,0,0", i, out_valid, x_sc, y_sc, clipped, in_ready, ey);
      end
    end
    @(negedge clk); in_valid = 1'b0;
    handshake("bp");
    repeat (15) @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ignored: got v=%0b r=%0b want 0,1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    out_ready = 1'b1;
    send(32'h4000_0000, 32'h2000_0000, 11'd1280, 11'd720);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ctrl: got v=%0b r=%0b want 0,1", out_valid, in_ready); end
    n_cmp++; if (x_sc !== 11'd0 || y_sc !== 11'd0 || clipped !== 1'b0) begin n_err++; $display("FAIL rst_mid_data: got %0d,%0d,%0b want 0,0,0", x_sc, y_sc, clipped); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || x_sc !== 11'd0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d bad cycles want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %0b want 1", in_ready); end
    out_ready = 1'b0;
    run_case("post_rst", 32'h7999_9999, 32'hF000_0000, 11'd1280, 11'd720, 11'd1279, FLIP ? 11'd719 : 11'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_unit_scaling();
    test_rounding();
    test_clamping();
    test_y_extremes();
    test_backpressure();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
